nec_ir_tx: RTL

Infrared transmitter that serialises a 32-bit NEC code onto a carrier-modulated IR LED output, forming the transmit end of the protocol that `IRController` receives. It sits beside the bus peripherals in the top level: CPU-written code registers drive `code`, and a write strobe drives `start` or `rpt`. It produces full NEC frames (leader, 32 data bits, stop mark) and NEC repeat frames, then holds a guard gap before accepting the next request.

---
 rtl/nec_ir_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC infrared transmitter. Serialises a latched 32-bit code
// (leader, 32 pulse-distance bits LSB first, stop mark) or a short repeat
// frame onto a carrier-modulated LED output, then holds a guard gap.
// Ports:
//   clk, res      - clock, asynchronous active-high reset
//   start, rpt    - full / repeat frame request (sampled only while idle)
//   code[31:0]    - frame payload, latched when start is accepted
//   busy          - frame or guard gap in progress
//   done          - one-cycle pulse at the end of the guard gap
//   envelope      - unmodulated mark signal
//   ir_out        - envelope gated by the carrier
module nec_ir_tx #(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter int unsigned CARRIER_DIV  = 1316,
    parameter int unsigned CARRIER_HIGH = 439,
    parameter int unsigned GAP_UNITS    = 64
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic        rpt,
    input  logic [31:0] code,
    output logic        busy,
    output logic        done,
    output logic        envelope,
    output logic        ir_out
);

    localparam int unsigned UW        = $clog2(UNIT_CYCLES + 1);
    localparam int unsigned CW        = $clog2(CARRIER_DIV + 1);
    localparam int unsigned MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int unsigned SW        = $clog2(MAX_UNITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [SW-1:0] su_q, su_d;
    logic [CW-1:0] car_q, car_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   code_q, code_d;
    logic          rep_q, rep_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          env_q, env_d;
    logic          ir_q, ir_d;
    logic [SW-1:0] dur;

    // Next-state, counters and output decode
    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        su_d    = su_q;
        bit_d   = bit_q;
        code_d  = code_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        car_d   = (car_q == CW'(CARRIER_DIV - 1)) ? '0 : car_q + CW'(1);

        // Length of the current state in NEC units
        unique case (state_q)
            LEAD_MARK:  dur = SW'(16);
            LEAD_SPACE: dur = rep_q ? SW'(4) : SW'(8);
            BIT_SPACE:  dur = code_q[bit_q] ? SW'(3) : SW'(1);
            GAP:        dur = SW'(GAP_UNITS);
            default:    dur = SW'(1);
        endcase

        if (state_q == IDLE) begin
            if (start || rpt) begin
                // start wins; a simultaneous rpt is dropped
                if (start) begin
                    code_d = code;
                    rep_d  = 1'b0;
                end else begin
                    rep_d  = 1'b1;
                end
                bit_d   = '0;
                unit_d  = '0;
                su_d    = '0;
                car_d   = '0;
                state_d = LEAD_MARK;
            end
        end else if (unit_q == UW'(UNIT_CYCLES - 1)) begin
            unit_d = '0;
            if (su_q == dur - SW'(1)) begin
                su_d = '0;
                unique case (state_q)
                    LEAD_MARK:  state_d = LEAD_SPACE;
                    LEAD_SPACE: state_d = rep_q ? STOP_MARK : BIT_MARK;
                    BIT_MARK:   state_d = BIT_SPACE;
                    BIT_SPACE: begin
                        if (bit_q == 5'd31) begin
                            state_d = STOP_MARK;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            state_d = BIT_MARK;
                        end
                    end
                    STOP_MARK:  state_d = GAP;
                    GAP: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                    default:    state_d = IDLE;
                endcase
            end else begin
                su_d = su_q + SW'(1);
            end
        end else begin
            unit_d = unit_q + UW'(1);
        end

        env_d  = (state_d == LEAD_MARK) || (state_d == BIT_MARK) ||
                 (state_d == STOP_MARK);
        ir_d   = env_d && (car_d < CW'(CARRIER_HIGH));
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            unit_q  <= '0;
            su_q    <= '0;
            car_q   <= '0;
            bit_q   <= '0;
            code_q  <= '0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            su_q    <= su_d;
            car_q   <= car_d;
            bit_q   <= bit_d;
            code_q  <= code_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            env_q   <= env_d;
            ir_q    <= ir_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign envelope = env_q;
    assign ir_out   = ir_q;

endmodule
